axi4_aw_qos_arbiter: RTL and testbench

Arbitrates the write-address (AW) channels of up to `NO_OF_MASTERS` AXI4 masters onto a single slave-side AW port. Selection is by highest AWQOS when QoS arbitration is enabled, with round-robin among equal-priority requesters. The block also limits outstanding writes to `OUTSTANDING_FIFO_DEPTH` by counting accepted AW beats against completed B handshakes. It sits between the master agents' AW channels and one slave's AW channel in the interconnect model.

---
 rtl/axi4_aw_qos_arbiter.sv | 136 +++++++++++++
 tb/tb_axi4_aw_qos_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_aw_qos_arbiter.sv
// AXI4 write-address arbiter: picks the highest-AWQOS requester (round-robin among ties)
// and throttles new grants once OUTSTANDING_FIFO_DEPTH writes are awaiting their B response.
module axi4_aw_qos_arbiter #(
    parameter int NO_OF_MASTERS          = 2,
    parameter int ADDRESS_WIDTH          = 64,
    parameter int OUTSTANDING_FIFO_DEPTH = 16,
    parameter int QOS_ENABLE             = 1
) (
    input  logic                                   aclk,
    input  logic                                   areset,
    input  logic [NO_OF_MASTERS-1:0]               m_awvalid,
    output logic [NO_OF_MASTERS-1:0]               m_awready,
    input  logic [NO_OF_MASTERS*4-1:0]             m_awid,
    input  logic [NO_OF_MASTERS*ADDRESS_WIDTH-1:0] m_awaddr,
    input  logic [NO_OF_MASTERS*8-1:0]             m_awlen,
    input  logic [NO_OF_MASTERS*4-1:0]             m_awqos,
    output logic                                   s_awvalid,
    input  logic                                   s_awready,
    output logic [3:0]                             s_awid,
    output logic [ADDRESS_WIDTH-1:0]               s_awaddr,
    output logic [7:0]                             s_awlen,
    output logic [3:0]                             s_awqos,
    output logic [$clog2(NO_OF_MASTERS)-1:0]       s_awmaster,
    input  logic                                   b_done,
    output logic [7:0]                             outstanding_count,
    output logic                                   ovf_err
);
    localparam int SW = $clog2(NO_OF_MASTERS);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]               state;
    logic [SW-1:0]            sel;
    logic [SW-1:0]            rr_ptr;
    logic [SW-1:0]            win;
    logic                     found;
    logic                     full;
    logic                     hs;
    logic [NO_OF_MASTERS-1:0] elig;
    logic [3:0]               max_prio;
    logic [3:0]               prio [NO_OF_MASTERS];

    assign full = (outstanding_count == 8'(OUTSTANDING_FIFO_DEPTH));
    assign hs   = (state == ST_GRANT) && s_awvalid && s_awready;

    always_comb begin
        for (int i = 0; i < NO_OF_MASTERS; i++) begin
            prio[i] = (QOS_ENABLE != 0) ? m_awqos[i*4 +: 4] : 4'd0;
        end
    end

    // Two passes give the wrap-around scan: first from rr_ptr upward, then from 0 to rr_ptr-1.
    always_comb begin
        elig     = full ? '0 : m_awvalid;
        max_prio = 4'd0;
        for (int i = 0; i < NO_OF_MASTERS; i++) begin
            if (elig[i] && (prio[i] > max_prio)) begin
                max_prio = prio[i];
            end
        end
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NO_OF_MASTERS; i++) begin
            if (!found && (i >= int'(rr_ptr)) && elig[i] && (prio[i] == max_prio)) begin
                win   = SW'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NO_OF_MASTERS; i++) begin
            if (!found && (i < int'(rr_ptr)) && elig[i] && (prio[i] == max_prio)) begin
                win   = SW'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        m_awready  = '0;
        s_awvalid  = 1'b0;
        s_awid     = '0;
        s_awaddr   = '0;
        s_awlen    = '0;
        s_awqos    = '0;
        s_awmaster = '0;
        if (state == ST_GRANT) begin
            s_awvalid      = m_awvalid[sel];
            m_awready[sel] = s_awready;
            s_awid         = m_awid[sel*4 +: 4];
            s_awaddr       = m_awaddr[sel*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            s_awlen        = m_awlen[sel*8 +: 8];
            s_awqos        = m_awqos[sel*4 +: 4];
            s_awmaster     = sel;
        end
    end

    // A grant is held until its handshake, so a later higher-QoS request never preempts it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state  <= ST_IDLE;
            sel    <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|elig) begin
                        sel   <= win;
                        state <= ST_GRANT;
                    end
                end
                default: begin
                    if (hs) begin
                        state  <= ST_IDLE;
                        rr_ptr <= (sel == SW'(NO_OF_MASTERS - 1)) ? '0 : sel + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            outstanding_count <= 8'd0;
            ovf_err           <= 1'b0;
        end else begin
            if (b_done && (outstanding_count == 8'd0)) begin
                ovf_err <= 1'b1;
            end
            if (hs && !b_done) begin
                outstanding_count <= outstanding_count + 8'd1;
            end else if (!hs && b_done && (outstanding_count != 8'd0)) begin
                outstanding_count <= outstanding_count - 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi4_aw_qos_arbiter.sv
// Scoreboard bench for axi4_aw_qos_arbiter: a transaction-level model predicts each grant,
// a negedge monitor compares every slave-side handshake and the counters against it.
module tb_axi4_aw_qos_arbiter;
    localparam int N     = 2;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int QOS   = 1;

    logic            aclk = 1'b0;
    logic            areset = 1'b1;
    logic [N-1:0]    m_awvalid = '0;
    logic [N-1:0]    m_awready;
    logic [N*4-1:0]  m_awid = '0;
    logic [N*AW-1:0] m_awaddr = '0;
    logic [N*8-1:0]  m_awlen = '0;
    logic [N*4-1:0]  m_awqos = '0;
    logic            s_awvalid;
    logic            s_awready = 1'b0;
    logic [3:0]      s_awid;
    logic [AW-1:0]   s_awaddr;
    logic [7:0]      s_awlen;
    logic [3:0]      s_awqos;
    logic [0:0]      s_awmaster;
    logic            b_done = 1'b0;
    logic [7:0]      outstanding_count;
    logic            ovf_err;

    always #5 aclk = ~aclk;

    axi4_aw_qos_arbiter #(
        .NO_OF_MASTERS(N), .ADDRESS_WIDTH(AW),
        .OUTSTANDING_FIFO_DEPTH(DEPTH), .QOS_ENABLE(QOS)
    ) dut (
        .aclk(aclk), .areset(areset),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awqos(m_awqos),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awqos(s_awqos),
        .s_awmaster(s_awmaster), .b_done(b_done),
        .outstanding_count(outstanding_count), .ovf_err(ovf_err)
    );

    typedef struct {
        int            master;
        logic [3:0]    id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [3:0]    qos;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    int   checks = 0;
    int   failures = 0;
    int   ready_pulses[N];
    int   auto_cnt[N];
    int   auto_qos[N];
    bit   rand_mode = 1'b0;

    bit   mdl_busy;
    int   mdl_sel;
    int   mdl_rr;
    int   mdl_count;
    bit   mdl_ovf;
    bit   mdl_hs[N];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdl_busy  = 1'b0;
        mdl_sel   = 0;
        mdl_rr    = 0;
        mdl_count = 0;
        mdl_ovf   = 1'b0;
        foreach (mdl_hs[i]) mdl_hs[i] = 1'b0;
        exp_q.delete();
    endtask

    // Grant choice: highest effective QoS, ties broken by smallest forward distance from rr.
    task automatic model_step();
        bit   hs;
        int   best, best_prio, best_dist, p, d;
        exp_t e;
        foreach (mdl_hs[i]) mdl_hs[i] = 1'b0;
        hs = mdl_busy && m_awvalid[mdl_sel] && s_awready;
        if (b_done && mdl_count == 0) mdl_ovf = 1'b1;
        if (mdl_busy) begin
            if (hs) begin
                mdl_hs[mdl_sel] = 1'b1;
                mdl_busy = 1'b0;
                mdl_rr = (mdl_sel + 1) % N;
            end
        end else if (mdl_count < DEPTH) begin
            best = -1; best_prio = 0; best_dist = 0;
            for (int i = 0; i < N; i++) begin
                if (m_awvalid[i]) begin
                    p = (QOS != 0) ? int'(m_awqos[i*4 +: 4]) : 0;
                    d = (i - mdl_rr + N) % N;
                    if (best < 0 || p > best_prio || (p == best_prio && d < best_dist)) begin
                        best = i; best_prio = p; best_dist = d;
                    end
                end
            end
            if (best >= 0) begin
                e.master = best;
                e.id     = m_awid[best*4 +: 4];
                e.addr   = m_awaddr[best*AW +: AW];
                e.len    = m_awlen[best*8 +: 8];
                e.qos    = m_awqos[best*4 +: 4];
                exp_q.push_back(e);
                mdl_busy = 1'b1;
                mdl_sel  = best;
            end
        end
        if (hs && !b_done) mdl_count++;
        else if (!hs && b_done && mdl_count > 0) mdl_count--;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge aclk or posedge areset);
            if (areset) model_reset();
            else model_step();
        end
    end

    task automatic monitor_cycle();
        exp_t e;
        check("s_awvalid", 64'(s_awvalid), 64'(mdl_busy && m_awvalid[mdl_sel]));
        check("count", 64'(outstanding_count), 64'(mdl_count));
        check("ovf_err", 64'(ovf_err), 64'(mdl_ovf));
        if (!mdl_busy)
            check("idle_outputs", 64'({m_awready, s_awid, s_awaddr, s_awlen, s_awqos, s_awmaster}), 64'(0));
        for (int i = 0; i < N; i++)
            if (m_awready[i] && m_awvalid[i]) ready_pulses[i]++;
        if (s_awvalid && s_awready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard_empty actual=handshake expected=none t=%0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("s_awmaster", 64'(s_awmaster), 64'(e.master));
                check("s_awid", 64'(s_awid), 64'(e.id));
                check("s_awaddr", 64'(s_awaddr), 64'(e.addr));
                check("s_awlen", 64'(s_awlen), 64'(e.len));
                check("s_awqos", 64'(s_awqos), 64'(e.qos));
                check("m_awready_onehot", 64'(m_awready), 64'(1) << e.master);
                grant_log.push_back(int'(s_awmaster));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge aclk);
            if (!areset) monitor_cycle();
        end
    end

    task automatic issue(int i, logic [3:0] id, logic [AW-1:0] addr, logic [7:0] len, logic [3:0] qos);
        m_awvalid[i]         = 1'b1;
        m_awid[i*4 +: 4]     = id;
        m_awaddr[i*AW +: AW] = addr;
        m_awlen[i*8 +: 8]    = len;
        m_awqos[i*4 +: 4]    = qos;
    endtask

    task automatic issue_rand(int i, int q);
        issue(i, 4'($urandom_range(0, 15)), AW'($urandom), 8'($urandom_range(0, 255)),
              (q < 0) ? 4'($urandom_range(0, 15)) : 4'(q));
    endtask

    // Masters keep AWVALID until the model reports their handshake, as AXI requires.
    task automatic step_cycle();
        @(posedge aclk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (mdl_hs[i]) begin
                m_awvalid[i] = 1'b0;
                if (auto_cnt[i] > 0) begin
                    auto_cnt[i]--;
                    issue_rand(i, auto_qos[i]);
                end
            end
        end
        if (rand_mode) begin
            s_awready = ($urandom_range(0, 3) != 0);
            b_done    = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < N; i++)
                if (!m_awvalid[i] && $urandom_range(0, 1) == 1) issue_rand(i, -1);
        end
    endtask

    task automatic wait_idle(string name, int budget);
        int n = 0;
        while ((m_awvalid != '0 || mdl_busy) && n < budget) begin
            step_cycle();
            n++;
        end
        check(name, 64'(n < budget), 64'(1));
    endtask

    task automatic do_reset();
        areset    = 1'b1;
        m_awvalid = '0;
        b_done    = 1'b0;
        s_awready = 1'b0;
        foreach (auto_cnt[i]) begin
            auto_cnt[i] = 0;
            auto_qos[i] = -1;
            ready_pulses[i] = 0;
        end
        repeat (2) @(posedge aclk);
        #2 areset = 1'b0;
        grant_log.delete();
    endtask

    task automatic check_order(string name, int n, int e0, int e1, int e2, int e3);
        int e[4];
        e = '{e0, e1, e2, e3};
        check({name, "_len"}, 64'(grant_log.size()), 64'(n));
        for (int k = 0; k < n && k < grant_log.size(); k++)
            check(name, 64'(grant_log[k]), 64'(e[k]));
    endtask

    task automatic applyStimulus();
        // Single request: one-cycle grant latency, then handshake.
        do_reset();
        check("reset_count", 64'(outstanding_count), 64'(0));
        check("reset_awvalid", 64'(s_awvalid), 64'(0));
        check("reset_ovf", 64'(ovf_err), 64'(0));
        check("reset_awready", 64'(m_awready), 64'(0));
        s_awready = 1'b1;
        issue(0, 4'd3, 32'h1000, 8'd7, 4'd0);
        step_cycle();
        check("single_latency", 64'(s_awvalid), 64'(1));
        check("single_id", 64'(s_awid), 64'(3));
        step_cycle();
        repeat (2) step_cycle();
        check("single_count", 64'(outstanding_count), 64'(1));
        check("single_ready_pulses", 64'(ready_pulses[0]), 64'(1));

        grant_log.delete();
        issue(0, 4'd1, 32'h2000, 8'd0, 4'd2);
        issue(1, 4'd2, 32'h3000, 8'd3, 4'd9);
        wait_idle("qos_timeout", 20);
        check_order("qos_order", 2, 1, 0, 0, 0);

        do_reset();
        s_awready = 1'b1;
        auto_cnt[0] = 1; auto_cnt[1] = 1;
        auto_qos[0] = 5; auto_qos[1] = 5;
        issue_rand(0, 5);
        issue_rand(1, 5);
        wait_idle("rr_timeout", 40);
        check_order("rr_order", 4, 0, 1, 0, 1);
        check("rr_count", 64'(outstanding_count), 64'(4));

        // Outstanding limit: six queued writes, no responses.
        do_reset();
        s_awready = 1'b1;
        auto_cnt[0] = 2; auto_cnt[1] = 2;
        issue_rand(0, 0);
        issue_rand(1, 0);
        repeat (20) step_cycle();
        check("full_handshakes", 64'(grant_log.size()), 64'(4));
        check("full_count", 64'(outstanding_count), 64'(DEPTH));
        check("full_awvalid", 64'(s_awvalid), 64'(0));
        b_done = 1'b1;
        step_cycle();
        b_done = 1'b0;
        repeat (4) step_cycle();
        check("full_release", 64'(grant_log.size()), 64'(5));
        check("full_release_count", 64'(outstanding_count), 64'(DEPTH));

        do_reset();
        s_awready = 1'b1;
        issue(0, 4'd4, 32'h4000, 8'd1, 4'd1);
        wait_idle("e_timeout0", 10);
        issue(1, 4'd5, 32'h5000, 8'd2, 4'd1);
        wait_idle("e_timeout1", 10);
        check("e_count2", 64'(outstanding_count), 64'(2));
        issue(0, 4'd6, 32'h6000, 8'd3, 4'd1);
        step_cycle();
        b_done = 1'b1;
        step_cycle();
        b_done = 1'b0;
        check("hs_and_bdone_count", 64'(outstanding_count), 64'(2));
        b_done = 1'b1;
        repeat (3) step_cycle();
        b_done = 1'b0;
        check("underflow_count", 64'(outstanding_count), 64'(0));
        check("underflow_ovf", 64'(ovf_err), 64'(1));
        repeat (5) step_cycle();
        check("ovf_sticky", 64'(ovf_err), 64'(1));

        // Asynchronous reset in the middle of a stalled grant.
        s_awready = 1'b0;
        issue(1, 4'd7, 32'h7000, 8'd4, 4'd3);
        step_cycle();
        check("f_granted", 64'(s_awvalid), 64'(1));
        #2 areset = 1'b1;
        #1;
        check("f_awvalid_drop", 64'(s_awvalid), 64'(0));
        check("f_awready_drop", 64'(m_awready), 64'(0));
        check("f_count_clear", 64'(outstanding_count), 64'(0));
        check("f_ovf_clear", 64'(ovf_err), 64'(0));
        m_awvalid = '0;
        @(posedge aclk);
        #2 areset = 1'b0;
        step_cycle();
        grant_log.delete();
        s_awready = 1'b1;
        issue(0, 4'd8, 32'h8000, 8'd5, 4'd4);
        issue(1, 4'd9, 32'h9000, 8'd6, 4'd4);
        wait_idle("f_timeout", 20);
        check_order("f_rr_reset_order", 2, 0, 1, 0, 0);

        rand_mode = 1'b1;
        repeat (400) step_cycle();
        rand_mode = 1'b0;
        s_awready = 1'b1;
        b_done    = 1'b1;
        wait_idle("rand_drain_timeout", 60);
        b_done = 1'b0;
    endtask

    task automatic checkOutput();
        step_cycle();
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus();
        checkOutput();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
